branch_redirect_ctrl: RTL and testbench

- Sequences control-flow changes after a branch/jump resolves in the branch slot of the VLIW execute stage.
- Computes the target, flushes the fetch/decode stages for a fixed number of cycles, then holds a PC redirect until fetch accepts it.
- Issues the link-register write for JAL/JALR.
- Sits between the branch execute unit (upstream, valid/ready) and the fetch unit (downstream, valid/ready).

---
 rtl/branch_redirect_ctrl.sv | 153 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Sequences a control-flow change once a branch/jump resolves in the VLIW
//   branch slot. It computes and registers the target, then holds flush for
//   FLUSH_CYCLES cycles. After that it offers the redirect to fetch until fetch
//   accepts it. For JAL/JALR it also issues a one-cycle link-register write.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   br_valid/br_ready   upstream handshake; ready only while idle
//   br_is_jmp           1 = JAL/JALR, 0 = conditional branch
//   br_is_imm_type      with br_is_jmp: 1 = JALR, 0 = JAL
//   br_taken            conditional-branch outcome (ignored for jumps)
//   br_pc, br_imm       branch PC and decoded immediate
//   br_rs1_val, br_rd   JALR base operand, link destination
//   flush               kill younger instructions in fetch/decode
//   redirect_valid/_pc  new PC offered to fetch; fetch_ready accepts it
//   link_we/rd/data     register-file write for the return address
//   misaligned          redirect_pc[1:0] != 0 while redirect_valid
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic        br_is_jmp,
  input  logic        br_is_imm_type,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [21:0] br_imm,
  input  logic [31:0] br_rs1_val,
  input  logic [4:0]  br_rd,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        fetch_ready,
  output logic        link_we,
  output logic [4:0]  link_rd,
  output logic [31:0] link_data,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_target;
  logic             r_mis;
  logic             r_link_we;
  logic [4:0]       r_link_rd;
  logic [31:0]      r_link_data;

  logic        w_accept;
  logic        w_redirect;
  logic        w_is_jalr;
  logic        w_link;
  logic [31:0] w_sext12;
  logic [31:0] w_sext20;
  logic [31:0] w_base;
  logic [31:0] w_addend;
  logic [32:0] w_sum33;
  logic [32:0] w_link33;
  logic [31:0] w_target;
  logic        w_unused;

  assign w_accept   = br_valid && (r_state == S_IDLE);
  assign w_redirect = br_is_jmp || br_taken;
  assign w_is_jalr  = br_is_jmp && br_is_imm_type;
  assign w_link     = w_accept && br_is_jmp && (br_rd != 5'd0);

  assign w_sext12 = {{20{br_imm[11]}}, br_imm[11:0]};
  assign w_sext20 = {{12{br_imm[19]}}, br_imm[19:0]};

  // One shared adder: JALR adds the unscaled offset to rs1; the PC-relative
  // forms add the halfword-scaled offset to br_pc.
  always_comb begin
    w_base   = br_pc;
    w_addend = {w_sext12[30:0], 1'b0};
    if (w_is_jalr) begin
      w_base   = br_rs1_val;
      w_addend = w_sext12;
    end else if (br_is_jmp) begin
      w_addend = {w_sext20[30:0], 1'b0};
    end
  end

  assign w_sum33  = {1'b0, w_base} + {1'b0, w_addend};
  assign w_target = {w_sum33[31:1], w_sum33[0] & ~w_is_jalr};
  assign w_link33 = {1'b0, br_pc} + 33'd4;

  assign w_unused = ^{br_imm[21:20], w_sum33[32], w_link33[32]};

  always_comb begin
    w_next         = r_state;
    br_ready       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        br_ready = 1'b1;
        if (br_valid && w_redirect) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (fetch_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign redirect_pc = r_target;
  assign misaligned  = redirect_valid && r_mis;
  assign link_we     = r_link_we;
  assign link_rd     = r_link_rd;
  assign link_data   = r_link_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_target    <= '0;
      r_mis       <= 1'b0;
      r_link_we   <= 1'b0;
      r_link_rd   <= '0;
      r_link_data <= '0;
    end else begin
      r_state   <= w_next;
      r_link_we <= w_link;
      if (w_link) begin
        r_link_rd   <= br_rd;
        r_link_data <= w_link33[31:0];
      end
      if (w_accept && w_redirect) begin
        r_target <= w_target;
        r_mis    <= |w_target[1:0];
        r_cnt    <= CNT_W'(FLUSH_CYCLES);
      end else if (r_state == S_FLUSH) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  localparam int unsigned FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic        br_is_jmp = 1'b0;
  logic        br_is_imm_type = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic [21:0] br_imm = '0;
  logic [31:0] br_rs1_val = '0;
  logic [4:0]  br_rd = '0;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_ready = 1'b0;
  logic        link_we;
  logic [4:0]  link_rd;
  logic [31:0] link_data;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .br_is_jmp(br_is_jmp), .br_is_imm_type(br_is_imm_type), .br_taken(br_taken),
    .br_pc(br_pc), .br_imm(br_imm), .br_rs1_val(br_rs1_val), .br_rd(br_rd),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .link_we(link_we), .link_rd(link_rd),
    .link_data(link_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference target from the architectural rules, using signed integer math.
  function automatic logic [31:0] ref_target(input logic jmp, input logic immt,
      input logic [31:0] pc, input logic [21:0] imm, input logic [31:0] rs1);
    longint t;
    logic [31:0] r;
    if (jmp && immt) begin
      t = longint'(rs1) + longint'($signed(imm[11:0]));
      r = t[31:0];
      r[0] = 1'b0;
    end else if (jmp) begin
      t = longint'(pc) + longint'($signed(imm[19:0])) * 2;
      r = t[31:0];
    end else begin
      t = longint'(pc) + longint'($signed(imm[11:0])) * 2;
      r = t[31:0];
    end
    return r;
  endfunction

  // Full transaction starting and ending at a negedge in IDLE.
  task automatic do_txn(input logic jmp, input logic immt, input logic tk,
      input logic [31:0] pc, input logic [21:0] imm, input logic [31:0] rs1,
      input logic [4:0] rd, input int unsigned stall);
    logic [31:0] exp_pc;
    logic [31:0] exp_link;
    logic        exp_taken;
    logic        exp_lwe;
    exp_pc    = ref_target(jmp, immt, pc, imm, rs1);
    exp_link  = pc + 32'd4;
    exp_taken = jmp || tk;
    exp_lwe   = jmp && (rd != 5'd0);

    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b expected 1", br_ready); end
    br_is_jmp = jmp; br_is_imm_type = immt; br_taken = tk; br_pc = pc;
    br_imm = imm; br_rs1_val = rs1; br_rd = rd; br_valid = 1'b1; fetch_ready = 1'b0;
    @(negedge clk);
    br_valid = 1'b0;
    checks++; if (link_we !== exp_lwe) begin errors++; $display("FAIL link_we: got %b expected %b", link_we, exp_lwe); end
    if (exp_lwe) begin
      checks++; if (link_rd !== rd) begin errors++; $display("FAIL link_rd: got %0d expected %0d", link_rd, rd); end
      checks++; if (link_data !== exp_link) begin errors++; $display("FAIL link_data: got %h expected %h", link_data, exp_link); end
    end
    if (!exp_taken) begin
      checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || br_ready !== 1'b1)
        begin errors++; $display("FAIL not_taken: got flush=%b rv=%b rdy=%b expected 0 0 1", flush, redirect_valid, br_ready); end
      return;
    end
    for (int unsigned i = 0; i < FLUSH; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0 || br_ready !== 1'b0)
        begin errors++; $display("FAIL flush_phase: cyc %0d got flush=%b rv=%b rdy=%b expected 1 0 0", i, flush, redirect_valid, br_ready); end
      if (i > 0) begin
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL link_once: got %b expected 0", link_we); end
      end
    end
    for (int unsigned s = 0; s <= stall; s++) begin
      @(negedge clk);
      checks++; if (redirect_valid !== 1'b1 || flush !== 1'b0 || br_ready !== 1'b0)
        begin errors++; $display("FAIL redirect_phase: got rv=%b flush=%b rdy=%b expected 1 0 0", redirect_valid, flush, br_ready); end
      checks++; if (redirect_pc !== exp_pc) begin errors++; $display("FAIL redirect_pc: got %h expected %h", redirect_pc, exp_pc); end
      checks++; if (misaligned !== (exp_pc[1:0] != 2'b00)) begin errors++; $display("FAIL misaligned: got %b expected %b", misaligned, exp_pc[1:0] != 2'b00); end
      if (s == stall) fetch_ready = 1'b1;
    end
    @(negedge clk);
    fetch_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b0 || br_ready !== 1'b1 || flush !== 1'b0 || misaligned !== 1'b0)
      begin errors++; $display("FAIL back_idle: got rv=%b rdy=%b flush=%b mis=%b expected 0 1 0 0", redirect_valid, br_ready, flush, misaligned); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || link_we !== 1'b0 || misaligned !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: got flush=%b rv=%b lwe=%b mis=%b expected 0 0 0 0", flush, redirect_valid, link_we, misaligned); end
    checks++; if (redirect_pc !== 32'd0 || link_rd !== 5'd0 || link_data !== 32'd0)
      begin errors++; $display("FAIL reset_data: got pc=%h rd=%0d ld=%h expected 0 0 0", redirect_pc, link_rd, link_data); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", br_ready); end
  endtask

  task automatic test_not_taken;
    do_txn(1'b0, 1'b0, 1'b0, 32'h100, 22'h8, 32'h0, 5'd4, 0);
    do_txn(1'b0, 1'b0, 1'b0, 32'h104, 22'hFF0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_directed;
    do_txn(1'b0, 1'b0, 1'b1, 32'h100, 22'h008, 32'h0, 5'd0, 0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h200, 22'hFFFF8, 32'h0, 5'd1, 0);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0, 22'h001, 32'h1003, 5'd0, 0);
    do_txn(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 22'h00004, 32'h0, 5'd2, 1);
    do_txn(1'b0, 1'b0, 1'b1, 32'h102, 22'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_stall_ignore;
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL stall_start: got %b expected 1", br_ready); end
    br_is_jmp = 1'b0; br_is_imm_type = 1'b0; br_taken = 1'b1; br_pc = 32'h300;
    br_imm = 22'h004; br_rd = 5'd0; br_valid = 1'b1; fetch_ready = 1'b0;
    @(negedge clk);
    // upstream now holds a JAL that must wait until the redirect completes
    br_is_jmp = 1'b1; br_pc = 32'h400; br_imm = 22'h10; br_rd = 5'd3;
    for (int unsigned i = 0; i < FLUSH; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (flush !== 1'b1 || br_ready !== 1'b0 || link_we !== 1'b0)
        begin errors++; $display("FAIL stall_flush: got flush=%b rdy=%b lwe=%b expected 1 0 0", flush, br_ready, link_we); end
    end
    for (int unsigned s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h308 || br_ready !== 1'b0 || link_we !== 1'b0)
        begin errors++; $display("FAIL stall_hold: got rv=%b pc=%h rdy=%b lwe=%b expected 1 00000308 0 0", redirect_valid, redirect_pc, br_ready, link_we); end
    end
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b0 || br_ready !== 1'b1 || link_we !== 1'b0)
      begin errors++; $display("FAIL stall_release: got rv=%b rdy=%b lwe=%b expected 0 1 0", redirect_valid, br_ready, link_we); end
    @(negedge clk);
    br_valid = 1'b0;
    checks++; if (link_we !== 1'b1 || link_rd !== 5'd3 || link_data !== 32'h404 || flush !== 1'b1)
      begin errors++; $display("FAIL held_accept: got lwe=%b rd=%0d ld=%h flush=%b expected 1 3 00000404 1", link_we, link_rd, link_data, flush); end
    repeat (FLUSH - 1) @(negedge clk);
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h420)
      begin errors++; $display("FAIL held_redirect: got rv=%b pc=%h expected 1 00000420", redirect_valid, redirect_pc); end
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    checks++; if (br_ready !== 1'b1 || redirect_valid !== 1'b0)
      begin errors++; $display("FAIL held_idle: got rdy=%b rv=%b expected 1 0", br_ready, redirect_valid); end
  endtask

  task automatic test_reset_mid_flush;
    br_is_jmp = 1'b1; br_is_imm_type = 1'b0; br_taken = 1'b0; br_pc = 32'h500;
    br_imm = 22'h40; br_rd = 5'd5; br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mid_flush_pre: got %b expected 1", flush); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || br_ready !== 1'b1 || link_we !== 1'b0)
      begin errors++; $display("FAIL mid_flush_rst: got flush=%b rv=%b rdy=%b lwe=%b expected 0 0 1 0", flush, redirect_valid, br_ready, link_we); end
    checks++; if (redirect_pc !== 32'd0 || link_rd !== 5'd0 || link_data !== 32'd0)
      begin errors++; $display("FAIL mid_flush_data: got pc=%h rd=%0d ld=%h expected 0 0 0", redirect_pc, link_rd, link_data); end
    for (int unsigned i = 0; i < FLUSH + 2; i++) begin
      @(negedge clk);
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0)
        begin errors++; $display("FAIL dropped_redirect: got rv=%b flush=%b expected 0 0", redirect_valid, flush); end
    end
  endtask

  task automatic test_random;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [21:0] imm;
    for (int n = 0; n < 40; n++) begin
      pc  = $urandom;
      rs1 = $urandom;
      imm = 22'($urandom);
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pc, imm, rs1, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_not_taken;
    test_directed;
    test_stall_ignore;
    test_reset_mid_flush;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
